// File: rtl/key_pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pulse_pkg
//  Description : Shared types and helpers for the key_pulse_bank conditioner:
//                per-channel state encoding and counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package key_pulse_pkg;

    // Per-channel conditioner states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Bits needed to hold values 0..max_val (never less than one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_pulse_channel.sv
`default_nettype none
// ============================================================================
//  Module      : key_pulse_channel
//  Description : One key channel: polarity normalisation, synchroniser chain,
//                debounce FSM with saturating counter, optional auto-repeat,
//                and registered press / held / release outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module key_pulse_channel
    import key_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_press,
    output logic o_held,
    output logic o_release
);

    localparam int c_cnt_w = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_deb     = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    // Reject configurations the datapath cannot honour
    generate
        if (SYNC_STAGES < 2) begin : g_chk_sync
            $error("key_pulse_channel: SYNC_STAGES must be >= 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
            $error("key_pulse_channel: DEBOUNCE_CYCLES must be >= 1");
        end
        if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_rpt
            $error("key_pulse_channel: REPEAT_DELAY and REPEAT_RATE must be >= 1");
        end
    endgenerate

    logic                   w_p;
    logic                   w_s;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    key_state_t             state_q, state_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d, w_cnt_inc;
    logic                   press_evt_q, press_evt_d;
    logic                   rel_evt_q, rel_evt_d;
    logic                   w_rpt_evt;
    logic                   key_out_q, key_out_d;
    logic                   held_q, held_d;
    logic                   release_q, release_d;

    // Normalise polarity so that 1 always means pressed; the synchroniser
    // therefore resets to 0, the inactive level.
    assign w_p = i_key ^ (ACTIVE_LOW != 0);
    assign w_s = sync_q[SYNC_STAGES-1];

    // Shift the normalised raw key through the synchroniser chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], w_p};
    end

    // Synchroniser register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Debounce FSM: a change is accepted once DEBOUNCE_CYCLES consecutive
    // synchronised samples disagree with the current debounced level.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_evt_d = 1'b0;
        rel_evt_d   = 1'b0;
        w_cnt_inc   = (cnt_q == c_deb) ? cnt_q : cnt_q + c_cnt_one;
        case (state_q)
            IDLE, PRESS_WAIT: begin
                if (!w_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (w_cnt_inc == c_deb) begin
                    state_d     = HELD;
                    cnt_d       = '0;
                    press_evt_d = 1'b1;
                end else begin
                    state_d = PRESS_WAIT;
                    cnt_d   = w_cnt_inc;
                end
            end
            HELD, RELEASE_WAIT: begin
                if (w_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (w_cnt_inc == c_deb) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    rel_evt_d = 1'b1;
                end else begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = w_cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, debounce counter and acceptance event registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            press_evt_q <= 1'b0;
            rel_evt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_evt_q <= press_evt_d;
            rel_evt_q   <= rel_evt_d;
        end
    end

    generate
        if (REPEAT_EN != 0) begin : g_repeat
            localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int c_rpt_w   = cnt_width(c_rpt_max);
            localparam logic [c_rpt_w-1:0] c_rpt_top   = c_rpt_w'(c_rpt_max);
            localparam logic [c_rpt_w-1:0] c_rpt_delay = c_rpt_w'(REPEAT_DELAY);
            localparam logic [c_rpt_w-1:0] c_rpt_rate  = c_rpt_w'(REPEAT_RATE);
            localparam logic [c_rpt_w-1:0] c_rpt_one   = c_rpt_w'(1);

            logic [c_rpt_w-1:0] rpt_q, rpt_d, w_rpt_inc, w_rpt_target;
            logic               armed_q, armed_d;
            logic               rpt_evt_q, rpt_evt_d;

            // Repeat timer: runs only while firmly held (frozen while a release
            // is being debounced); first period is the delay, then the rate.
            always_comb begin
                rpt_d        = rpt_q;
                armed_d      = armed_q;
                rpt_evt_d    = 1'b0;
                w_rpt_inc    = (rpt_q == c_rpt_top) ? rpt_q : rpt_q + c_rpt_one;
                w_rpt_target = armed_q ? c_rpt_rate : c_rpt_delay;
                if (press_evt_d) begin
                    rpt_d   = '0;
                    armed_d = 1'b0;
                end else if (state_q == HELD && w_s) begin
                    if (w_rpt_inc == w_rpt_target) begin
                        rpt_evt_d = 1'b1;
                        rpt_d     = '0;
                        armed_d   = 1'b1;
                    end else begin
                        rpt_d = w_rpt_inc;
                    end
                end
            end

            // Repeat timer registers
            always_ff @(posedge clk) begin
                if (rst) begin
                    rpt_q     <= '0;
                    armed_q   <= 1'b0;
                    rpt_evt_q <= 1'b0;
                end else begin
                    rpt_q     <= rpt_d;
                    armed_q   <= armed_d;
                    rpt_evt_q <= rpt_evt_d;
                end
            end

            assign w_rpt_evt = rpt_evt_q;
        end else begin : g_no_repeat
            assign w_rpt_evt = 1'b0;
        end
    endgenerate

    // Output values derived from the registered FSM events and state
    always_comb begin
        key_out_d = press_evt_q | w_rpt_evt;
        held_d    = (state_q == HELD) || (state_q == RELEASE_WAIT);
        release_d = rel_evt_q;
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            key_out_q <= 1'b0;
            held_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            key_out_q <= key_out_d;
            held_q    <= held_d;
            release_q <= release_d;
        end
    end

    assign o_press   = key_out_q;
    assign o_held    = held_q;
    assign o_release = release_q;

endmodule
`default_nettype wire

// File: rtl/key_pulse_bank.sv
`default_nettype none
// ============================================================================
//  Module      : key_pulse_bank
//  Description : Multi-channel key conditioner for the game player inputs.
//                N_KEYS independent channels, each synchronised, debounced and
//                converted to press / held / release indications.
//  Revision    : 1.0  initial release
// ============================================================================
module key_pulse_bank
    import key_pulse_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 0,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] keyOut,
    output logic [N_KEYS-1:0] keyHeld,
    output logic [N_KEYS-1:0] keyRelease
);

    // One fully independent conditioner per key
    generate
        for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
            key_pulse_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .ACTIVE_LOW     (ACTIVE_LOW),
                .REPEAT_EN      (REPEAT_EN),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_chan (
                .clk      (clk),
                .rst      (reset),
                .i_key    (key[g]),
                .o_press  (keyOut[g]),
                .o_held   (keyHeld[g]),
                .o_release(keyRelease[g])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_pulse_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_pulse_bank
//  Description : Self-checking bench for key_pulse_bank. Three instances share
//                one stimulus: default, auto-repeat, and active-low (inverted
//                keys). A sample-history reference model predicts outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_pulse_bank;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 16;
    localparam int RR = 4;

    logic         clk, reset;
    logic [N-1:0] key, key_n;
    logic [N-1:0] ko_a, kh_a, kr_a, ko_r, kh_r, kr_r, ko_l, kh_l, kr_l;

    assign key_n = ~key;

    key_pulse_bank #(.N_KEYS(N)) dut_a (
        .clk(clk), .reset(reset), .key(key),
        .keyOut(ko_a), .keyHeld(kh_a), .keyRelease(kr_a));
    key_pulse_bank #(.N_KEYS(N), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_r (
        .clk(clk), .reset(reset), .key(key),
        .keyOut(ko_r), .keyHeld(kh_r), .keyRelease(kr_r));
    key_pulse_bank #(.N_KEYS(N), .ACTIVE_LOW(1)) dut_l (
        .clk(clk), .reset(reset), .key(key_n),
        .keyOut(ko_l), .keyHeld(kh_l), .keyRelease(kr_l));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: raw-sample history, debounced level, length of
    // the current run of disagreeing samples, and count of firmly-held samples
    logic [N-1:0] exp_out, exp_out_r, exp_held, exp_rel;
    logic [N-1:0] pend_press, pend_rpt, pend_rel, level;
    logic [S-1:0] hist [N];
    int           run    [N];
    int           hcount [N];

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            logic s;
            logic firm;
            if (reset) begin
                hist[c] = '0; level[c] = 1'b0; run[c] = 0; hcount[c] = 0;
                pend_press[c] = 1'b0; pend_rpt[c] = 1'b0; pend_rel[c] = 1'b0;
                exp_out[c] = 1'b0; exp_out_r[c] = 1'b0; exp_held[c] = 1'b0; exp_rel[c] = 1'b0;
            end else begin
                exp_out[c]   = pend_press[c];
                exp_out_r[c] = pend_press[c] | pend_rpt[c];
                exp_rel[c]   = pend_rel[c];
                exp_held[c]  = level[c];
                pend_press[c] = 1'b0; pend_rpt[c] = 1'b0; pend_rel[c] = 1'b0;
                s       = hist[c][S-1];
                hist[c] = {hist[c][S-2:0], key[c]};
                firm    = level[c] && (run[c] == 0);
                if (firm && s) begin
                    hcount[c]++;
                    if (hcount[c] >= RD && ((hcount[c] - RD) % RR) == 0) pend_rpt[c] = 1'b1;
                end
                if (s != level[c]) begin
                    run[c]++;
                    if (run[c] == D) begin
                        level[c] = s;
                        run[c]   = 0;
                        if (s) begin
                            pend_press[c] = 1'b1;
                            hcount[c]     = 0;
                        end else begin
                            pend_rel[c] = 1'b1;
                        end
                    end
                end else begin
                    run[c] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key   = '0;
        repeat (5) begin
            tick();
            total++;
            if ({ko_a, kh_a, kr_a, ko_r, kh_r, kr_r, ko_l, kh_l, kr_l} !== '0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got a=%b%b%b r=%b%b%b l=%b%b%b exp all zero",
                         cyc, ko_a, kh_a, kr_a, ko_r, kh_r, kr_r, ko_l, kh_l, kr_l);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_press_release();
        key = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({ko_a, kh_a, kr_a} !== {exp_out, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL press_model cyc=%0d got=%b exp=%b", cyc, {ko_a, kh_a, kr_a}, {exp_out, exp_held, exp_rel});
            end
            total++;
            if (ko_a[0] !== (i == 6) || kh_a[0] !== (i >= 6)) begin
                bad++;
                $display("FAIL press_timing E0+%0d got out=%b held=%b exp out=%b held=%b",
                         i, ko_a[0], kh_a[0], (i == 6), (i >= 6));
            end
        end
        key = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (kr_a[0] !== (i == 6) || kh_a[0] !== (i < 6)) begin
                bad++;
                $display("FAIL release_timing E0+%0d got rel=%b held=%b exp rel=%b held=%b",
                         i, kr_a[0], kh_a[0], (i == 6), (i < 6));
            end
        end
    endtask

    task automatic test_glitch();
        key = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) key = '0;
            tick();
            total++;
            if ({ko_a, kh_a, kr_a} !== '0 || {ko_l, kh_l, kr_l} !== '0) begin
                bad++;
                $display("FAIL glitch_rejected cyc=%0d got a=%b l=%b exp zero", cyc, {ko_a, kh_a, kr_a}, {ko_l, kh_l, kr_l});
            end
        end
        key = 4'b0010;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) key = '0;
            tick();
            total++;
            if (ko_a[1] !== (i == 6)) begin
                bad++;
                $display("FAIL four_edge_press E0+%0d got=%b exp=%b", i, ko_a[1], (i == 6));
            end
            total++;
            if ({ko_l, kh_l, kr_l} !== {exp_out, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL four_edge_low cyc=%0d got=%b exp=%b", cyc, {ko_l, kh_l, kr_l}, {exp_out, exp_held, exp_rel});
            end
        end
    endtask

    task automatic test_release_bounce();
        int presses;
        presses = 0;
        key = 4'b1000;
        repeat (10) tick();
        for (int i = 0; i < 3; i++) begin
            key = (i == 2) ? 4'b1000 : 4'b0000;
            tick();
            if (ko_a[3]) presses++;
        end
        key = '0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (ko_a[3]) presses++;
            total++;
            if (kr_a[3] !== (j == 6)) begin
                bad++;
                $display("FAIL bounce_release F+%0d got=%b exp=%b", j, kr_a[3], (j == 6));
            end
            total++;
            if ({ko_a, kh_a, kr_a} !== {exp_out, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, {ko_a, kh_a, kr_a}, {exp_out, exp_held, exp_rel});
            end
        end
        total++;
        if (presses != 0) begin
            bad++;
            $display("FAIL bounce_extra_press got=%0d exp=0", presses);
        end
    endtask

    task automatic test_repeat();
        key = 4'b0001;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (ko_r[0] !== (i == 6 || (i >= 22 && ((i - 22) % 4) == 0))) begin
                bad++;
                $display("FAIL repeat_timing E0+%0d got=%b exp=%b", i, ko_r[0], (i == 6 || (i >= 22 && ((i - 22) % 4) == 0)));
            end
            total++;
            if (ko_a[0] !== (i == 6)) begin
                bad++;
                $display("FAIL norepeat_single E0+%0d got=%b exp=%b", i, ko_a[0], (i == 6));
            end
        end
        key = '0;
        for (int j = 0; j < 12; j++) begin
            tick();
            total++;
            if ({ko_r, kh_r, kr_r} !== {exp_out_r, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL repeat_release_model cyc=%0d got=%b exp=%b", cyc, {ko_r, kh_r, kr_r}, {exp_out_r, exp_held, exp_rel});
            end
            total++;
            if (j >= 6 && ko_r[0] !== 1'b0) begin
                bad++;
                $display("FAIL repeat_after_release E'+%0d got=%b exp=0", j, ko_r[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        key = 4'b0100;
        repeat (10) tick();
        total++;
        if (kh_a[2] !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_preheld got=%b exp=1", kh_a[2]);
        end
        reset = 1'b1;
        tick();
        total++;
        if ({ko_a, kh_a, kr_a, ko_r, kh_r, kr_r} !== '0) begin
            bad++;
            $display("FAIL reset_mid_clear got a=%b r=%b exp zero", {ko_a, kh_a, kr_a}, {ko_r, kh_r, kr_r});
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ko_a[2] !== (i == 6) || ko_r[2] !== (i == 6)) begin
                bad++;
                $display("FAIL reset_mid_repress R+%0d got a=%b r=%b exp=%b", i, ko_a[2], ko_r[2], (i == 6));
            end
        end
        key = '0;
        repeat (10) tick();
    endtask

    task automatic test_all_keys();
        key = '1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (ko_a !== ((i == 6) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL all_keys_same_edge E0+%0d got=%b exp=%b", i, ko_a, (i == 6) ? 4'hF : 4'h0);
            end
            total++;
            if ({ko_l, kh_l, kr_l} !== {exp_out, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL all_keys_low cyc=%0d got=%b exp=%b", cyc, {ko_l, kh_l, kr_l}, {exp_out, exp_held, exp_rel});
            end
        end
        key = '0;
        repeat (10) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 6) == 0) key[c] = ~key[c];
            reset = ($urandom_range(0, 99) == 0);
            tick();
            total++;
            if ({ko_a, kh_a, kr_a} !== {exp_out, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL random_default cyc=%0d got=%b exp=%b", cyc, {ko_a, kh_a, kr_a}, {exp_out, exp_held, exp_rel});
            end
            total++;
            if ({ko_r, kh_r, kr_r} !== {exp_out_r, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL random_repeat cyc=%0d got=%b exp=%b", cyc, {ko_r, kh_r, kr_r}, {exp_out_r, exp_held, exp_rel});
            end
            total++;
            if ({ko_l, kh_l, kr_l} !== {exp_out, exp_held, exp_rel}) begin
                bad++;
                $display("FAIL random_low cyc=%0d got=%b exp=%b", cyc, {ko_l, kh_l, kr_l}, {exp_out, exp_held, exp_rel});
            end
            total++;
            if ((ko_a & kr_a) !== '0 || (ko_r & kr_r) !== '0) begin
                bad++;
                $display("FAIL random_out_rel_overlap cyc=%0d got a=%b r=%b exp 0000", cyc, ko_a & kr_a, ko_r & kr_r);
            end
        end
        reset = 1'b0;
        key   = '0;
        repeat (10) tick();
    endtask

    initial begin
        reset = 1'b1;
        key   = '0;
        test_reset();
        test_press_release();
        test_glitch();
        test_release_bounce();
        test_repeat();
        test_reset_mid();
        test_all_keys();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
